// File: rtl/proc_pkg.sv
// Shared processor constants and the instruction-memory loader state type.
package proc_pkg;

    localparam int INSTR_W = 33;
    localparam int PC_W    = 9;
    localparam int DATA_W  = 18;

    typedef enum logic [2:0] {
        LEN   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_t;

    // States in which the loader takes bytes from the stream.
    function automatic logic takes_bytes(input loader_state_t st);
        return (st == LEN) || (st == DATA) || (st == CHECK);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects little-endian stream bytes into one instruction word; the final byte
// is taken straight from the input so the completed word is visible on its accept cycle.
module word_assembler #(
    parameter int INSTR_W        = 33,
    parameter int BYTES_PER_WORD = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_in,
    output logic               word_full,
    output logic [INSTR_W-1:0] word,
    output logic               pad_err
);
    localparam int HOLD_W = 8 * (BYTES_PER_WORD - 1);
    localparam int CNT_W  = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_WORD - 1);

    logic [HOLD_W-1:0]           hold_r;
    logic [CNT_W-1:0]            cnt_r;
    logic [8*BYTES_PER_WORD-1:0] full_s;

    assign full_s    = {byte_in, hold_r};
    assign word_full = byte_valid && (cnt_r == LAST);
    assign word      = full_s[INSTR_W-1:0];
    assign pad_err   = |full_s[8*BYTES_PER_WORD-1:INSTR_W];

    // Shift earlier bytes in from the top so byte 0 ends up in bits 7:0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_r <= '0;
            cnt_r  <= '0;
        end else if (clear) begin
            hold_r <= '0;
            cnt_r  <= '0;
        end else if (word_full) begin
            cnt_r  <= '0;
        end else if (byte_valid) begin
            hold_r <= {byte_in, hold_r[HOLD_W-1:8]};
            cnt_r  <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, 5-byte little-endian words written to imem,
// XOR checksum; releases the pipeline reset only after a clean load.
module imem_loader #(
    parameter int INSTR_W        = proc_pkg::INSTR_W,
    parameter int ADDR_W         = proc_pkg::PC_W,
    parameter int BYTES_PER_WORD = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_req,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_rst,
    output logic               done,
    output logic               error
);
    import proc_pkg::*;

    localparam logic [15:0] MAX_WORDS = 16'(2 ** ADDR_W);

    loader_state_t      state_r, next_state_s;
    logic               accept_s, restart_s;
    logic [15:0]        len_r, n_s;
    logic               len_hi_r;
    logic [7:0]         acc_r;
    logic [ADDR_W:0]    idx_r, idx_next_s;
    logic               asm_full_s, asm_pad_s;
    logic [INSTR_W-1:0] asm_word_s;
    logic               rx_ready_r, imem_we_r, cpu_rst_r, done_r, error_r;
    logic [ADDR_W-1:0]  imem_addr_r;
    logic [INSTR_W-1:0] imem_wdata_r;

    assign accept_s   = rx_valid && rx_ready_r;
    assign restart_s  = load_req && ((state_r == DONE) || (state_r == ERR));
    assign n_s        = {rx_data, len_r[7:0]};
    assign idx_next_s = idx_r + {{ADDR_W{1'b0}}, 1'b1};

    assign rx_ready   = rx_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_rst    = cpu_rst_r;
    assign done       = done_r;
    assign error      = error_r;

    word_assembler #(
        .INSTR_W        (INSTR_W),
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (restart_s),
        .byte_valid (accept_s && (state_r == DATA)),
        .byte_in    (rx_data),
        .word_full  (asm_full_s),
        .word       (asm_word_s),
        .pad_err    (asm_pad_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= LEN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            LEN: begin
                if (accept_s && len_hi_r) begin
                    if ((n_s == 16'd0) || (n_s > MAX_WORDS)) next_state_s = ERR;
                    else                                     next_state_s = DATA;
                end else begin
                    next_state_s = LEN;
                end
            end
            DATA: begin
                if (asm_full_s) begin
                    if (asm_pad_s) next_state_s = ERR;
                    else           next_state_s = WRITE;
                end else begin
                    next_state_s = DATA;
                end
            end
            WRITE: begin
                if (16'(idx_next_s) == len_r) next_state_s = CHECK;
                else                          next_state_s = DATA;
            end
            CHECK: begin
                if (accept_s) begin
                    if (rx_data == acc_r) next_state_s = DONE;
                    else                  next_state_s = ERR;
                end else begin
                    next_state_s = CHECK;
                end
            end
            DONE, ERR: begin
                if (load_req) next_state_s = LEN;
                else          next_state_s = state_r;
            end
            default: next_state_s = ERR;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= '0;
            cpu_rst_r    <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            rx_ready_r <= takes_bytes(next_state_s);
            imem_we_r  <= (next_state_s == WRITE);
            cpu_rst_r  <= (next_state_s == DONE);
            done_r     <= (next_state_s == DONE);
            error_r    <= (next_state_s == ERR);
            if (next_state_s == WRITE) begin
                imem_addr_r  <= idx_r[ADDR_W-1:0];
                imem_wdata_r <= asm_word_s;
            end
        end
    end

    // Length header, checksum accumulator and word index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_r    <= 16'd0;
            len_hi_r <= 1'b0;
            acc_r    <= 8'd0;
            idx_r    <= '0;
        end else if (restart_s) begin
            len_r    <= 16'd0;
            len_hi_r <= 1'b0;
            acc_r    <= 8'd0;
            idx_r    <= '0;
        end else begin
            if (accept_s && (state_r != CHECK)) begin
                acc_r <= acc_r ^ rx_data;
            end
            if (accept_s && (state_r == LEN)) begin
                len_hi_r <= ~len_hi_r;
                if (len_hi_r) len_r[15:8] <= rx_data;
                else          len_r[7:0]  <= rx_data;
            end
            if (state_r == WRITE) begin
                idx_r <= idx_next_s;
            end
        end
    end

endmodule
